shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_ctrl_if.sv | 33 +++
 rtl/shift_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the ALU-op decoder and the shift sequencer.
// Latency: n/a (wires only).
// Backpressure: none; the requester watches busy and start is ignored while busy.
//
// Signals:
//   start      request pulse (master -> slave)
//   op         3-bit shift op code (master -> slave)
//   in_a       operand (master -> slave)
//   num_shifts shift amount, low CNT_W bits used (master -> slave)
//   busy       request in progress (slave -> master)
//   done       one-cycle completion strobe (slave -> master)
//   out        last completed result (slave -> master)
interface shift_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] in_a;
   logic [31:0]      num_shifts;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;

   modport master (
      output start, op, in_a, num_shifts,
      input  busy, done, out
   );

   modport slave (
      input  start, op, in_a, num_shifts,
      output busy, done, out
   );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Iterative shift/rotate sequencer: latches one request, steps the working register per clock, strobes done.
// Latency: k+1 cycles from the start edge (1 cycle for k=0 or pass-through); ceil(k/4)+1 with SHIFT_FAST_EN.
// Backpressure: none; start is accepted only in IDLE, otherwise dropped (not queued).
//
// Ports:
//   clk  - system clock, rising edge
//   clr  - synchronous active-high reset, highest priority
//   sif  - slave side of shift_seq_ctrl_if (start/op/in_a/num_shifts in, busy/done/out out)
// Optional macro SHIFT_FAST_EN: up to 4 bits per SHIFT cycle instead of 1.
module shift_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic              clk,
   input  logic              clr,
   shift_seq_ctrl_if.slave   sif
);

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] w_work_nxt;
   logic [2:0]       r_op;
   logic [2:0]       w_op_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_req_cnt;
   logic [WIDTH-1:0] r_out;
   logic             w_unused_hi;

`ifdef SHIFT_FAST_EN
   logic [CNT_W-1:0] w_step;
   // Bits consumed this cycle: min(cnt, 4).
   assign w_step = (r_cnt > CNT_W'(4)) ? CNT_W'(4) : r_cnt;
`endif

   // Only the low CNT_W bits of the amount matter (amount mod 2**CNT_W).
   assign w_req_cnt   = sif.num_shifts[CNT_W-1:0];
   assign w_unused_hi = ^sif.num_shifts[31:CNT_W];

   // One single-bit step of the selected op; unknown codes leave the value alone.
   function automatic logic [WIDTH-1:0] f_step1(input logic [WIDTH-1:0] v, input logic [2:0] o);
      logic [WIDTH-1:0] r;
      case (o)
         OP_SHR:  r = {1'b0, v[WIDTH-1:1]};
         OP_SHRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
         OP_SHL:  r = {v[WIDTH-2:0], 1'b0};
         OP_ROR:  r = {v[0], v[WIDTH-1:1]};
         OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         default: r = v;
      endcase
      return r;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_op_nxt    = r_op;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (sif.start) begin
               w_work_nxt = sif.in_a;
               w_op_nxt   = sif.op;
               w_cnt_nxt  = w_req_cnt;
               // Zero count or pass-through op completes with the operand untouched.
               if ((w_req_cnt != '0) && (sif.op <= OP_ROL)) begin
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_SHIFT: begin
`ifdef SHIFT_FAST_EN
            for (int i = 0; i < 4; i++) begin
               if (CNT_W'(i) < w_step) begin
                  w_work_nxt = f_step1(w_work_nxt, r_op);
               end
            end
            w_cnt_nxt = r_cnt - w_step;
`else
            w_work_nxt = f_step1(r_work, r_op);
            w_cnt_nxt  = r_cnt - CNT_W'(1);
`endif
            if (w_cnt_nxt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_op    <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_op    <= w_op_nxt;
         r_cnt   <= w_cnt_nxt;
         // Result register updates on the edge entering DONE so out is valid alongside done.
         if (w_state_nxt == S_DONE) begin
            r_out <= w_work_nxt;
         end
      end
   end

   assign sif.busy = (r_state != S_IDLE);
   assign sif.done = (r_state == S_DONE);
   assign sif.out  = r_out;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: vector table, random model vectors, hand sequences.
// Latency: checks done timing against k+1 (or ceil(k/4)+1 with SHIFT_FAST_EN).
// Backpressure: exercises start while busy, start in DONE, and clr mid-operation.
module tb_shift_seq_ctrl;

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] ns;
      logic [31:0] exp_out;
   } vec_t;

   typedef struct {
      logic [31:0] out;
      int          lat;
   } exp_t;

   logic clk;
   logic clr;
   int   checks;
   int   failures;
   exp_t sb_q[$];
   vec_t vecs[10];

   shift_seq_ctrl_if #(.WIDTH(32)) sif ();

   shift_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
      .clk (clk),
      .clr (clr),
      .sif (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] ns);
      int k;
      logic signed [31:0] s;
      k = int'(ns[4:0]);
      s = a;
      case (op)
         OP_SHR:  return a >> k;
         OP_SHRA: return s >>> k;
         OP_SHL:  return a << k;
         OP_ROR:  return (k == 0) ? a : ((a >> k) | (a << (32 - k)));
         OP_ROL:  return (k == 0) ? a : ((a << k) | (a >> (32 - k)));
         default: return a;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] ns);
      int k;
      k = int'(ns[4:0]);
      if (k == 0 || op > OP_ROL) return 1;
`ifdef SHIFT_FAST_EN
      return (k + 3) / 4 + 1;
`else
      return k + 1;
`endif
   endfunction

   // Drive one request, push its expectation, then wait (bounded) for done and score it.
   task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] ns,
                          input logic [31:0] exp_out, input int glitch_cyc, input bit start_in_done);
      exp_t e;
      int   cyc;
      bit   got;
      e.out = exp_out;
      e.lat = exp_lat(op, ns);
      sb_q.push_back(e);
      sif.op = op; sif.in_a = a; sif.num_shifts = ns; sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      sif.in_a = $urandom; sif.op = 3'($urandom_range(0, 7)); sif.num_shifts = $urandom;
      cyc = 1;
      got = 1'b0;
      while (!got && cyc <= 100) begin
         if (sif.done) begin
            got = 1'b1;
         end else begin
            chk("busy_during_run", 32'(sif.busy), 32'd1);
            sif.start = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) begin
               sif.in_a = $urandom; sif.num_shifts = 32'd3; sif.op = OP_ROL;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      sif.start = 1'b0;
      e = sb_q.pop_front();
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done_within_100");
      end else begin
         chk("done_latency", 32'(cyc), 32'(e.lat));
         chk("result", sif.out, e.out);
         chk("busy_in_done", 32'(sif.busy), 32'd1);
      end
      if (start_in_done) begin
         sif.start = 1'b1; sif.op = OP_SHL; sif.in_a = 32'h1; sif.num_shifts = 32'd5;
      end
      @(posedge clk); #1;
      sif.start = 1'b0;
      chk("done_one_cycle", 32'(sif.done), 32'd0);
      chk("idle_after_done", 32'(sif.busy), 32'd0);
      chk("out_held", sif.out, e.out);
   endtask

   initial begin
      bit saw_done;
      checks   = 0;
      failures = 0;
      clr = 1'b1;
      sif.start = 1'b0; sif.op = '0; sif.in_a = '0; sif.num_shifts = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(sif.busy), 32'd0);
      chk("reset_done", 32'(sif.done), 32'd0);
      chk("reset_out", sif.out, 32'd0);
      clr = 1'b0;
      @(posedge clk); #1;

      vecs[0] = '{OP_SHRA, 32'h80000010, 32'd4,  32'hF8000001};
      vecs[1] = '{OP_SHR,  32'h80000010, 32'd4,  32'h08000001};
      vecs[2] = '{OP_SHL,  32'h00000003, 32'd30, 32'hC0000000};
      vecs[3] = '{OP_ROR,  32'h00000001, 32'd1,  32'h80000000};
      vecs[4] = '{OP_ROL,  32'h80000000, 32'd33, 32'h00000001};
      vecs[5] = '{OP_SHRA, 32'h12345678, 32'd32, 32'h12345678};
      vecs[6] = '{3'b110,  32'h12345678, 32'd5,  32'h12345678};
      vecs[7] = '{OP_SHL,  32'h00000001, 32'd31, 32'h80000000};
      vecs[8] = '{OP_SHRA, 32'h80000000, 32'd6,  32'hFE000000};
      vecs[9] = '{OP_ROL,  32'h0000F00D, 32'd16, 32'hF00D0000};
      foreach (vecs[i]) begin
         run_req(vecs[i].op, vecs[i].a, vecs[i].ns, vecs[i].exp_out, 0, 1'b0);
      end

      // Random operands checked against a native-operator model.
      for (int i = 0; i < 12; i++) begin
         logic [2:0]  op;
         logic [31:0] a;
         logic [31:0] ns;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         ns = $urandom;
         run_req(op, a, ns, model(op, a, ns), 0, 1'b0);
      end

      // Start pulsed again in cycle 3 while busy: dropped.
      run_req(OP_SHR, 32'hFFFFFFFF, 32'd8, 32'h00FFFFFF, 3, 1'b0);

      // Start held during the DONE cycle: dropped, bench checks IDLE afterwards.
      run_req(OP_ROR, 32'h000000F1, 32'd4, 32'h1000000F, 0, 1'b1);

      // clr in cycle 4 aborts: no done, out cleared.
      sif.op = OP_SHR; sif.in_a = 32'hFFFFFFFF; sif.num_shifts = 32'd20; sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      saw_done = 1'b0;
      repeat (3) begin
         if (sif.done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_busy", 32'(sif.busy), 32'd0);
      chk("clr_out", sif.out, 32'd0);
      repeat (25) begin
         if (sif.done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      chk("clr_no_done", 32'(saw_done), 32'd0);

      // Sequencer accepts work again after the abort.
      run_req(OP_SHL, 32'h00000005, 32'd2, 32'h00000014, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
